// File: rtl/particle_evt_pkg.sv
// Shared types and constants for the particle event packer.
// Build option: PARTICLE_EVT_PEAK_POS_EN adds a peak offset field to the
// event record (and the evt_peak_ofs_o port on the top).
package particle_evt_pkg;
  localparam int POS_WIDTH = 24;
  localparam int LEN_WIDTH = 8;
  localparam int PEAK_W    = 16;
`ifdef PARTICLE_EVT_PEAK_POS_EN
  localparam int PEAK_OFS_W = LEN_WIDTH;
`else
  localparam int PEAK_OFS_W = 0;
`endif
  localparam int EVT_W = POS_WIDTH + LEN_WIDTH + PEAK_W + 1 + PEAK_OFS_W;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  typedef struct packed {
    logic [POS_WIDTH-1:0] start;
    logic [LEN_WIDTH-1:0] len;
    logic [PEAK_W-1:0]    peak;
    logic                 acc;
`ifdef PARTICLE_EVT_PEAK_POS_EN
    logic [LEN_WIDTH-1:0] peak_ofs;
`endif
  } evt_t;
endpackage

// File: rtl/particle_evt_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk_i/rst_i (sync, active-high), push_i/wdata_i write side,
// pop_i/rdata_o read side (rdata_o valid whenever !empty_o), full_o, empty_o.
// A push while full is accepted only if a pop happens in the same cycle.
module particle_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: empty flag masks stale words.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/particle_event_packer.sv
// Groups confirmed hit samples of the particle filter stream into events and
// queues them on a valid/ready output.
// Ports: clk_i/rst_i (sync, active-high); track_start_i; filter_* sample
// stream; evt_ready_i downstream ready; evt_vld_o/evt_start_o/evt_len_o/
// evt_peak_o/evt_acc_flag_o event record (zero while !evt_vld_o);
// evt_overflow_o sticky drop flag; evt_count_o accepted-event counter.
// Build option: PARTICLE_EVT_PEAK_POS_EN adds evt_peak_ofs_o.
module particle_event_packer
  import particle_evt_pkg::*;
#(
  parameter int GAP_MAX    = 2,
  parameter int MIN_LEN    = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 track_start_i,
  input  logic                 filter_vld_i,
  input  logic                 filter_acc_flag_i,
  input  logic [15:0]          filter_haze_hub_i,
  input  logic                 filter_curr_result_i,
  input  logic                 filter_cache_result_i,
  input  logic                 evt_ready_i,
  output logic                 evt_vld_o,
  output logic [POS_WIDTH-1:0] evt_start_o,
  output logic [LEN_WIDTH-1:0] evt_len_o,
  output logic [15:0]          evt_peak_o,
  output logic                 evt_acc_flag_o,
`ifdef PARTICLE_EVT_PEAK_POS_EN
  output logic [LEN_WIDTH-1:0] evt_peak_ofs_o,
`endif
  output logic                 evt_overflow_o,
  output logic [15:0]          evt_count_o
);
  localparam int GAP_W = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  state_t               state_q, state_d;
  // cur_q.len holds the length up to the last hit; run_len_q counts every
  // valid sample since the event start, gaps included.
  evt_t                 cur_q, cur_d, close_rec, push_rec_q, push_rec_d, head;
  logic [LEN_WIDTH-1:0] run_len_q, run_len_d, run_len_inc;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d, pos_cur;
  logic                 push_q, push_d, close, hit;
  logic                 ovf_q, ovf_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 full, empty, pop, push_ok;

  always_comb begin
    hit         = filter_vld_i & filter_curr_result_i & filter_cache_result_i;
    pos_cur     = track_start_i ? '0 : pos_q;
    pos_d       = filter_vld_i ? pos_cur + 1'b1 : pos_cur;
    state_d     = state_q;
    cur_d       = cur_q;
    run_len_d   = run_len_q;
    run_len_inc = run_len_q + 1'b1;
    gap_d       = gap_q;
    close       = 1'b0;
    close_rec   = cur_q;

    // New track: flush the open event before looking at this sample.
    if (track_start_i && state_q != IDLE) begin
      close   = 1'b1;
      state_d = IDLE;
    end

    if (filter_vld_i) begin
      if (state_q == IDLE || track_start_i) begin
        if (hit) begin
          cur_d.start = pos_cur;
          cur_d.len   = LEN_WIDTH'(1);
          cur_d.peak  = filter_haze_hub_i;
          cur_d.acc   = filter_acc_flag_i;
`ifdef PARTICLE_EVT_PEAK_POS_EN
          cur_d.peak_ofs = '0;
`endif
          run_len_d   = LEN_WIDTH'(1);
          gap_d       = '0;
          state_d     = RUN;
        end
      end else begin
        run_len_d = run_len_inc;
        if (hit) begin
          cur_d.len = run_len_inc;
          cur_d.acc = cur_q.acc | filter_acc_flag_i;
          // Strict compare keeps the first occurrence of the peak.
          if (filter_haze_hub_i > cur_q.peak) begin
            cur_d.peak = filter_haze_hub_i;
`ifdef PARTICLE_EVT_PEAK_POS_EN
            cur_d.peak_ofs = run_len_q;
`endif
          end
          gap_d   = '0;
          state_d = RUN;
        end else if (state_q == RUN) begin
          if (GAP_MAX == 0) begin
            close   = 1'b1;
            state_d = IDLE;
          end else begin
            gap_d   = GAP_W'(1);
            state_d = GAP;
          end
        end else if (gap_q == GAP_W'(GAP_MAX)) begin
          close   = 1'b1;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
        if (run_len_inc == LEN_MAX) begin
          close   = 1'b1;
          state_d = IDLE;
        end
        close_rec = cur_d;
      end
    end

    push_d     = close && (close_rec.len >= LEN_WIDTH'(MIN_LEN));
    push_rec_d = close_rec;
  end

  always_comb begin
    pop     = ~empty & evt_ready_i;
    push_ok = push_q & (~full | pop);
    ovf_d   = ovf_q | (push_q & full & ~pop);
    cnt_d   = cnt_q + {15'd0, push_ok};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      run_len_q  <= '0;
      gap_q      <= '0;
      pos_q      <= '0;
      push_q     <= 1'b0;
      push_rec_q <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      run_len_q  <= run_len_d;
      gap_q      <= gap_d;
      pos_q      <= pos_d;
      push_q     <= push_d;
      push_rec_q <= push_rec_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  particle_evt_fifo #(.WIDTH(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_ok),
    .wdata_i (push_rec_q),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign evt_vld_o      = ~empty;
  assign evt_start_o    = evt_vld_o ? head.start : '0;
  assign evt_len_o      = evt_vld_o ? head.len   : '0;
  assign evt_peak_o     = evt_vld_o ? head.peak  : '0;
  assign evt_acc_flag_o = evt_vld_o & head.acc;
`ifdef PARTICLE_EVT_PEAK_POS_EN
  assign evt_peak_ofs_o = evt_vld_o ? head.peak_ofs : '0;
`endif
  assign evt_overflow_o = ovf_q;
  assign evt_count_o    = cnt_q;
endmodule

// File: tb/tb_particle_event_packer.sv
// Directed bench for particle_event_packer (default parameters).
module tb_particle_event_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ts = 1'b0, vld = 1'b0, acc = 1'b0, curr = 1'b0, cache = 1'b0;
  logic [15:0] haze = '0;
  logic        rdy = 1'b1;
  logic        evt_vld, evt_acc, evt_ovf;
  logic [23:0] evt_start;
  logic [7:0]  evt_len;
  logic [15:0] evt_peak, evt_cnt;
`ifdef PARTICLE_EVT_PEAK_POS_EN
  logic [7:0]  evt_peak_ofs;
`endif

  int checks = 0, failures = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [23:0] s;
    logic [7:0]  l;
    logic [15:0] p;
    logic        a;
  } rec_t;
  rec_t mon_q[$];

  always #5 clk = ~clk;

  particle_event_packer dut (
    .clk_i(clk), .rst_i(rst), .track_start_i(ts), .filter_vld_i(vld),
    .filter_acc_flag_i(acc), .filter_haze_hub_i(haze),
    .filter_curr_result_i(curr), .filter_cache_result_i(cache),
    .evt_ready_i(rdy), .evt_vld_o(evt_vld), .evt_start_o(evt_start),
    .evt_len_o(evt_len), .evt_peak_o(evt_peak), .evt_acc_flag_o(evt_acc),
`ifdef PARTICLE_EVT_PEAK_POS_EN
    .evt_peak_ofs_o(evt_peak_ofs),
`endif
    .evt_overflow_o(evt_ovf), .evt_count_o(evt_cnt)
  );

  // Inputs change at posedge+1, so negedge sees a stable handshake.
  always @(negedge clk)
    if (evt_vld && rdy) mon_q.push_back('{evt_start, evt_len, evt_peak, evt_acc});

  task automatic drive(input logic t, v, c, k, input logic [15:0] h, input logic a);
    ts = t; vld = v; curr = c; cache = k; haze = h; acc = a;
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 16'd0, 0);
  endtask
  task automatic nh(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 16'd999, 0);
  endtask
  task automatic hit(input logic [15:0] h, input logic a);
    drive(0, 1, 1, 1, h, a);
  endtask
  task automatic new_track();
    drive(1, 0, 0, 0, 16'd0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(3);
    checks++; if (evt_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got %0b exp 0", evt_vld); end
    checks++; if (evt_start !== 24'd0 || evt_len !== 8'd0 || evt_peak !== 16'd0 || evt_acc !== 1'b0) begin
      failures++; $display("FAIL reset_fields got %0d/%0d/%0d/%0b exp 0", evt_start, evt_len, evt_peak, evt_acc); end
    checks++; if (evt_ovf !== 1'b0 || evt_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_stat got ovf=%0b cnt=%0d exp 0/0", evt_ovf, evt_cnt); end
    rst = 1'b0; idle(2);
  endtask

  task automatic test_basic();
    mon_q.delete(); new_track(); nh(10);
    hit(16'd100, 0); hit(16'd300, 1); hit(16'd200, 0); nh(3);
    checks++; if (evt_vld !== 1'b0) begin failures++; $display("FAIL basic_lat_early got %0b exp 0", evt_vld); end
    idle(1);
    checks++; if (evt_vld !== 1'b1) begin failures++; $display("FAIL basic_lat got %0b exp 1", evt_vld); end
    checks++; if (evt_start !== 24'd10 || evt_len !== 8'd3 || evt_peak !== 16'd300 || evt_acc !== 1'b1) begin
      failures++; $display("FAIL basic_fields got %0d/%0d/%0d/%0b exp 10/3/300/1", evt_start, evt_len, evt_peak, evt_acc); end
`ifdef PARTICLE_EVT_PEAK_POS_EN
    checks++; if (evt_peak_ofs !== 8'd1) begin failures++; $display("FAIL basic_peak_ofs got %0d exp 1", evt_peak_ofs); end
`endif
    idle(3); exp_cnt += 1;
    checks++; if (mon_q.size() != 1) begin failures++; $display("FAIL basic_count got %0d exp 1", mon_q.size()); end
    checks++; if (evt_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL basic_evt_cnt got %0d exp %0d", evt_cnt, exp_cnt); end
  endtask

  task automatic test_gap();
    rec_t exp [2];
    mon_q.delete(); new_track(); nh(5);
    hit(16'd7, 0); hit(16'd9, 0); nh(1); hit(16'd8, 0); nh(3); idle(4);
    exp_cnt += 1;
    checks++; if (mon_q.size() != 1) begin failures++; $display("FAIL gap_bridge_n got %0d exp 1", mon_q.size()); end
    else begin
      checks++; if (mon_q[0].s !== 24'd5 || mon_q[0].l !== 8'd4 || mon_q[0].p !== 16'd9) begin
        failures++; $display("FAIL gap_bridge got %0d/%0d/%0d exp 5/4/9", mon_q[0].s, mon_q[0].l, mon_q[0].p); end
    end
    mon_q.delete(); new_track(); nh(5);
    hit(16'd1, 0); hit(16'd2, 0); nh(3); hit(16'd3, 1); hit(16'd4, 0); nh(3); idle(4);
    exp_cnt += 2;
    exp[0] = '{24'd5, 8'd2, 16'd2, 1'b0};
    exp[1] = '{24'd10, 8'd2, 16'd4, 1'b1};
    checks++; if (mon_q.size() != 2) begin failures++; $display("FAIL gap_split_n got %0d exp 2", mon_q.size()); end
    for (int i = 0; i < 2 && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i].s !== exp[i].s || mon_q[i].l !== exp[i].l || mon_q[i].p !== exp[i].p || mon_q[i].a !== exp[i].a) begin
        failures++; $display("FAIL gap_split[%0d] got %0d/%0d/%0d/%0b exp %0d/%0d/%0d/%0b", i,
          mon_q[i].s, mon_q[i].l, mon_q[i].p, mon_q[i].a, exp[i].s, exp[i].l, exp[i].p, exp[i].a); end
    end
  endtask

  task automatic test_min_len();
    mon_q.delete(); new_track(); nh(20);
    hit(16'd50, 1); nh(3);
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 16'd60, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 1, 16'd60, 0);
    nh(3); idle(4);
    checks++; if (mon_q.size() != 0) begin failures++; $display("FAIL min_len_n got %0d exp 0", mon_q.size()); end
    checks++; if (evt_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL min_len_cnt got %0d exp %0d", evt_cnt, exp_cnt); end
  endtask

  task automatic test_saturation();
    mon_q.delete(); new_track();
    for (int i = 0; i < 300; i++) hit(16'(i), 0);
    nh(3); idle(4); exp_cnt += 2;
    checks++; if (mon_q.size() != 2) begin failures++; $display("FAIL sat_n got %0d exp 2", mon_q.size()); end
    else begin
      checks++; if (mon_q[0].s !== 24'd0 || mon_q[0].l !== 8'd255 || mon_q[0].p !== 16'd254) begin
        failures++; $display("FAIL sat_first got %0d/%0d/%0d exp 0/255/254", mon_q[0].s, mon_q[0].l, mon_q[0].p); end
      checks++; if (mon_q[1].s !== 24'd255 || mon_q[1].l !== 8'd45 || mon_q[1].p !== 16'd299) begin
        failures++; $display("FAIL sat_second got %0d/%0d/%0d exp 255/45/299", mon_q[1].s, mon_q[1].l, mon_q[1].p); end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] h_s; logic [7:0] h_l; logic [15:0] h_p;
    mon_q.delete(); rdy = 1'b0; new_track();
    for (int k = 0; k < 17; k++) begin
      hit(16'(k + 1), 0); hit(16'(k), 0); nh(3);
      if (k == 0) begin idle(1); h_s = evt_start; h_l = evt_len; h_p = evt_peak; end
    end
    idle(3); exp_cnt += 16;
    checks++; if (evt_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got %0b exp 1", evt_ovf); end
    checks++; if (evt_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL ovf_cnt got %0d exp %0d", evt_cnt, exp_cnt); end
    checks++; if (h_s !== 24'd0 || h_l !== 8'd2 || h_p !== 16'd1) begin
      failures++; $display("FAIL ovf_head got %0d/%0d/%0d exp 0/2/1", h_s, h_l, h_p); end
    checks++; if (evt_vld !== 1'b1 || evt_start !== 24'd0 || evt_len !== 8'd2 || evt_peak !== 16'd1) begin
      failures++; $display("FAIL ovf_stable got %0b %0d/%0d/%0d exp 1 0/2/1", evt_vld, evt_start, evt_len, evt_peak); end
    rdy = 1'b1; idle(20);
    checks++; if (mon_q.size() != 16) begin failures++; $display("FAIL ovf_drain_n got %0d exp 16", mon_q.size()); end
    for (int k = 0; k < 16 && k < mon_q.size(); k++) begin
      checks++;
      if (mon_q[k].s !== 24'(5 * k) || mon_q[k].l !== 8'd2 || mon_q[k].p !== 16'(k + 1)) begin
        failures++; $display("FAIL ovf_order[%0d] got %0d/%0d/%0d exp %0d/2/%0d", k,
          mon_q[k].s, mon_q[k].l, mon_q[k].p, 5 * k, k + 1); end
    end
    checks++; if (evt_ovf !== 1'b1 || evt_vld !== 1'b0) begin
      failures++; $display("FAIL ovf_sticky got ovf=%0b vld=%0b exp 1/0", evt_ovf, evt_vld); end
  endtask

  task automatic test_track_start();
    mon_q.delete(); new_track(); nh(3);
    hit(16'd10, 0); hit(16'd30, 0); hit(16'd20, 0);
    drive(1, 1, 1, 1, 16'd50, 1);
    hit(16'd40, 0); nh(3); idle(4); exp_cnt += 2;
    checks++; if (mon_q.size() != 2) begin failures++; $display("FAIL ts_n got %0d exp 2", mon_q.size()); end
    else begin
      checks++; if (mon_q[0].s !== 24'd3 || mon_q[0].l !== 8'd3 || mon_q[0].p !== 16'd30) begin
        failures++; $display("FAIL ts_old got %0d/%0d/%0d exp 3/3/30", mon_q[0].s, mon_q[0].l, mon_q[0].p); end
      checks++; if (mon_q[1].s !== 24'd0 || mon_q[1].l !== 8'd2 || mon_q[1].p !== 16'd50 || mon_q[1].a !== 1'b1) begin
        failures++; $display("FAIL ts_new got %0d/%0d/%0d/%0b exp 0/2/50/1", mon_q[1].s, mon_q[1].l, mon_q[1].p, mon_q[1].a); end
    end
  endtask

  task automatic test_reset_mid();
    mon_q.delete(); new_track();
    hit(16'd5, 0); hit(16'd6, 0);
    rst = 1'b1; idle(1); rst = 1'b0;
    checks++; if (evt_vld !== 1'b0 || evt_ovf !== 1'b0 || evt_cnt !== 16'd0 || evt_start !== 24'd0) begin
      failures++; $display("FAIL rst_mid_out got vld=%0b ovf=%0b cnt=%0d start=%0d exp 0", evt_vld, evt_ovf, evt_cnt, evt_start); end
    nh(3); idle(6);
    checks++; if (mon_q.size() != 0) begin failures++; $display("FAIL rst_mid_lost got %0d exp 0", mon_q.size()); end
    hit(16'd8, 0); hit(16'd9, 0); nh(3); idle(4);
    checks++; if (mon_q.size() != 1) begin failures++; $display("FAIL rst_after_n got %0d exp 1", mon_q.size()); end
    else begin
      checks++; if (mon_q[0].s !== 24'd3 || mon_q[0].l !== 8'd2 || mon_q[0].p !== 16'd9) begin
        failures++; $display("FAIL rst_after got %0d/%0d/%0d exp 3/2/9", mon_q[0].s, mon_q[0].l, mon_q[0].p); end
    end
    checks++; if (evt_cnt !== 16'd1) begin failures++; $display("FAIL rst_after_cnt got %0d exp 1", evt_cnt); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_gap();
    test_min_len();
    test_saturation();
    test_overflow();
    test_track_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/particle_event_packer.md
Name: particle_event_packer

Overview:
- Consumer-side counterpart of the particle filter stage.
- Takes the per-sample filter stream (valid, data, haze hub, current/cache threshold results) and groups confirmed hit samples into particle events.
- Buffers completed events in a small FIFO and presents them downstream on a valid/ready interface for packetising toward the PMT data uplink.

Parameters:
POS_WIDTH, 24, width of sample position counter and event start index
LEN_WIDTH, 8, width of event length field (saturating)
GAP_MAX, 2, max consecutive valid non-hit samples tolerated inside one event
MIN_LEN, 2, minimum event length in samples; shorter runs are discarded
FIFO_DEPTH, 16, event FIFO depth (power of two)

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset; one clock; reset is synchronous and active-high
track_start_i  input  1  start of new track: clears position, force-closes open event
filter_vld_i  input  1  sample valid
filter_acc_flag_i  input  1  accumulation flag of sample
filter_haze_hub_i  input  16  haze-subtracted amplitude of sample
filter_curr_result_i  input  1  current-spot threshold hit
filter_cache_result_i  input  1  cached-spot (one spacing back) threshold hit
evt_ready_i  input  1  downstream ready
evt_vld_o  output  1  event valid
evt_start_o  output  POS_WIDTH  position of first hit sample
evt_len_o  output  LEN_WIDTH  samples from first to last hit, inclusive
evt_peak_o  output  16  max haze_hub over hit samples
evt_acc_flag_o  output  1  OR of acc_flag over hit samples
evt_overflow_o  output  1  sticky: event dropped because FIFO full
evt_count_o  output  16  events accepted into FIFO since reset, wraps

Behaviour:
- Reset: every output and all internal state 0; FIFO emptied; FSM goes to IDLE.
- hit = filter_vld_i & filter_curr_result_i & filter_cache_result_i. Cycles with filter_vld_i=0 are ignored: they are not gaps and do not advance position.
- Position counter: +1 per filter_vld_i, wraps at 2^POS_WIDTH. track_start_i zeroes it; a sample in the same cycle gets index 0 and the counter becomes 1.
- FSM states:
  - IDLE: on hit, capture start=pos, len=1, peak=haze_hub, acc=acc_flag, last_len=1; go to RUN.
  - RUN: on hit, extend len and update peak/acc. On a valid non-hit, gap=1 and go to GAP, unless GAP_MAX=0, which closes the event.
  - GAP: len counts every valid sample. On hit, last_len=len, gap=0, return to RUN. On a valid non-hit with gap==GAP_MAX, close the event. Otherwise gap+1.
- Close:
  - Reported length is last_len, so trailing gap samples are excluded.
  - If last_len ≥ MIN_LEN, push to the FIFO on the next cycle; otherwise drop silently.
  - FSM returns to IDLE in the same cycle as the close. A hit on the next valid sample starts a new event.
- Saturation: when len reaches 2^LEN_WIDTH−1, the event closes on that sample, regardless of state.
- track_start_i while RUN/GAP: close the open event first (MIN_LEN rule applies). A same-cycle hit then starts a new event with start=0.
- FIFO:
  - Push with FIFO full: the event is discarded, evt_overflow_o set (cleared only by rst_i), evt_count_o not incremented.
  - Simultaneous pop and push with FIFO full: the push succeeds.
- Output: first-word fall-through. evt_vld_o rises 1 cycle after the push into an empty FIFO. Fields stay stable while evt_vld_o & !evt_ready_i. Pop on evt_vld_o & evt_ready_i.
- Latency: closing sample at cycle N → FIFO write N+1 → evt_vld_o at N+2 (FIFO empty).
- Reset mid-event: the event is lost and not emitted.

Optional Feature:
PARTICLE_EVT_PEAK_POS_EN
- Defined: adds output evt_peak_ofs_o [LEN_WIDTH], the sample offset of the peak from start. On ties the first occurrence wins. The FIFO word widens accordingly.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package particle_evt_pkg:
  - state enum (IDLE, RUN, GAP)
  - event record type (start, len, peak, acc, optional peak_ofs)
  - packed width constant derived from POS_WIDTH/LEN_WIDTH
  - the macro-dependent field width
- One sub-module: particle_evt_fifo, a parameterised synchronous FWFT FIFO with full/empty flags.

Test Plan:
- Hits on positions 10,11,12 then 3 non-hits (GAP_MAX=2) → one event: start=10, len=3, peak=max, evt_vld_o 2 cycles after the 3rd non-hit.
- Hits at 5,6, non-hit at 7, hit at 8, then 3 non-hits → single event: start=5, len=4. With hits 5,6 and 3 non-hits at 7–9 → event len=2; a hit at 10 starts a new event.
- Single hit at 20 (MIN_LEN=2) → no event; evt_count_o unchanged. Also curr_result=1 with cache_result=0 → no event.
- 300 consecutive hits from position 0 → event start=0, len=255, then a new event starting at 255.
- evt_ready_i=0, 17 separated events → 16 held, evt_overflow_o=1, evt_count_o=16. Raise ready → 16 pops in order, fields stable while stalled.
- track_start_i asserted mid-event (len=3) with a same-cycle hit → old event emitted with len=3; new event start=0. rst_i mid-event → all outputs 0, nothing emitted.
